// File: rtl/pcm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcm_pkg
// Purpose  : State encoding, error codes and phase helpers for pcm_seq_checker.
// Revision : 1.0 - initial release
// ============================================================================
package pcm_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        P3   = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_ONEHOT = 3'd1;
    localparam logic [2:0] ERR_ORDER  = 3'd2;
    localparam logic [2:0] ERR_LONG   = 3'd3;
    localparam logic [2:0] ERR_SHORT  = 3'd4;

    localparam int PH_LEN_DEFAULT = 3;

    // Line pattern that keeps a phase state alive.
    function automatic logic [2:0] own_bits(input state_t s);
        case (s)
            P1:      own_bits = 3'b001;
            P2:      own_bits = 3'b010;
            P3:      own_bits = 3'b100;
            default: own_bits = 3'b000;
        endcase
    endfunction

    // Line pattern that legally ends a phase; P3 ends on idle lines.
    function automatic logic [2:0] next_bits(input state_t s);
        case (s)
            P1:      next_bits = 3'b010;
            P2:      next_bits = 3'b100;
            default: next_bits = 3'b000;
        endcase
    endfunction

    function automatic state_t next_phase(input state_t s);
        case (s)
            P1:      next_phase = P2;
            P2:      next_phase = P3;
            default: next_phase = IDLE;
        endcase
    endfunction

endpackage : pcm_pkg
`default_nettype wire

// File: rtl/pcm_sync3.sv
`default_nettype none
// ============================================================================
// Module   : pcm_sync3
// Purpose  : 3-bit two-flop synchronizer for the asynchronous phase lines.
// Revision : 1.0 - initial release
// ============================================================================
module pcm_sync3 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] i_d,
    output logic [2:0] o_q
);

    logic [2:0] r_meta;
    logic [2:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 3'b000;
            r_sync <= 3'b000;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : pcm_sync3
`default_nettype wire

// File: rtl/pcm_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : pcm_seq_checker
// Purpose  : Checks q1->q2->q3 phase sequences of PH_LEN clocks each and
//            reports done/err pulses with saturating counts.
//            Define PCM_SYNC_EN to synchronize q1..q3 through pcm_sync3.
// Revision : 1.0 - initial release
// ============================================================================
module pcm_seq_checker
    import pcm_pkg::*;
#(
    parameter int PH_LEN = PH_LEN_DEFAULT,
    parameter int LEN_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             q1,
    input  logic             q2,
    input  logic             q3,
    output logic             busy,
    output logic [1:0]       phase,
    output logic             done,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] seq_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [LEN_W-1:0] c_PH_LEN = LEN_W'(PH_LEN);

    logic [2:0] w_v;

`ifdef PCM_SYNC_EN
    pcm_sync3 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   ({q3, q2, q1}),
        .o_q   (w_v)
    );
`else
    assign w_v = {q3, q2, q1};
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] w_len_nxt;
    logic             w_done;
    logic             w_err;
    logic [2:0]       w_code;
    logic             w_multi;
    logic [2:0]       w_state_bits;

    logic             r_busy;
    logic [1:0]       r_phase;
    logic             r_done;
    logic             r_err;
    logic [2:0]       r_code;
    logic [CNT_W-1:0] r_seq_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    assign w_multi = (w_v & (w_v - 3'd1)) != 3'd0;

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_code      = ERR_NONE;

        if (r_state == ERR) begin
            // Violations inside ERR are swallowed; only idle lines release it.
            if (w_v == 3'b000) begin
                w_state_nxt = IDLE;
            end
            w_len_nxt = '0;
        end else if (w_multi) begin
            w_state_nxt = ERR;
            w_len_nxt   = '0;
            w_err       = 1'b1;
            w_code      = ERR_ONEHOT;
        end else if (r_state == IDLE) begin
            if (w_v == 3'b001) begin
                w_state_nxt = P1;
                w_len_nxt   = LEN_W'(1);
            end else if (w_v != 3'b000) begin
                w_state_nxt = ERR;
                w_err       = 1'b1;
                w_code      = ERR_ORDER;
            end
        end else begin
            w_state_nxt = ERR;
            w_len_nxt   = '0;
            w_err       = 1'b1;
            if (w_v == own_bits(r_state)) begin
                if (r_len < c_PH_LEN) begin
                    w_state_nxt = r_state;
                    w_len_nxt   = r_len + LEN_W'(1);
                    w_err       = 1'b0;
                end else begin
                    w_code = ERR_LONG;
                end
            end else if (w_v == next_bits(r_state)) begin
                if (r_len == c_PH_LEN) begin
                    w_state_nxt = next_phase(r_state);
                    w_len_nxt   = (r_state == P3) ? '0 : LEN_W'(1);
                    w_done      = (r_state == P3);
                    w_err       = 1'b0;
                end else begin
                    w_code = ERR_SHORT;
                end
            end else begin
                w_code = ERR_ORDER;
            end
        end
    end

    assign w_state_bits = w_state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_len     <= '0;
            r_busy    <= 1'b0;
            r_phase   <= 2'd0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_code    <= ERR_NONE;
            r_seq_cnt <= '0;
            r_err_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_len   <= w_len_nxt;
            r_busy  <= (w_state_nxt == P1) || (w_state_nxt == P2) || (w_state_nxt == P3);
            r_phase <= (w_state_nxt == ERR) ? 2'd0 : w_state_bits[1:0];
            r_done  <= w_done;
            r_err   <= w_err;
            if (w_err) begin
                r_code <= w_code;
            end
            if (w_done && (r_seq_cnt != '1)) begin
                r_seq_cnt <= r_seq_cnt + 1'b1;
            end
            if (w_err && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign busy     = r_busy;
    assign phase    = r_phase;
    assign done     = r_done;
    assign err      = r_err;
    assign err_code = r_code;
    assign seq_cnt  = r_seq_cnt;
    assign err_cnt  = r_err_cnt;

endmodule : pcm_seq_checker
`default_nettype wire

// File: tb/tb_pcm_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcm_seq_checker
// Purpose  : Directed table-driven bench for pcm_seq_checker (PH_LEN=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcm_seq_checker;

    logic       clk;
    logic       rst_n;
    logic       q1, q2, q3;
    logic       busy;
    logic [1:0] phase;
    logic       done;
    logic       err;
    logic [2:0] err_code;
    logic [7:0] seq_cnt;
    logic [7:0] err_cnt;

    int checks   = 0;
    int failures = 0;

    pcm_seq_checker #(.PH_LEN(3), .LEN_W(4), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .q1       (q1),
        .q2       (q2),
        .q3       (q3),
        .busy     (busy),
        .phase    (phase),
        .done     (done),
        .err      (err),
        .err_code (err_code),
        .seq_cnt  (seq_cnt),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] v;
        logic [1:0] phase;
        logic       busy;
        logic       done;
        logic       err;
        logic [2:0] code;
        logic [7:0] scnt;
        logic [7:0] ecnt;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] b_scnt = 8'd0;
    logic [7:0] b_ecnt = 8'd0;
    logic [2:0] b_code = 3'd0;

    // Expected counts and held code are bookkept by hand as rows are listed.
    task automatic add(input logic [2:0] v, input logic [1:0] ph, input logic d,
                       input logic e, input logic [2:0] code);
        vec_t r;
        if (d) b_scnt = b_scnt + 8'd1;
        if (e) begin
            b_ecnt = b_ecnt + 8'd1;
            b_code = code;
        end
        r.v = v; r.phase = ph; r.busy = (ph != 2'd0); r.done = d; r.err = e;
        r.code = b_code; r.scnt = b_scnt; r.ecnt = b_ecnt;
        tbl.push_back(r);
    endtask

    task automatic add_rep(input logic [2:0] v, input logic [1:0] ph, input int n);
        for (int k = 0; k < n; k++) add(v, ph, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic add_legal();
        add_rep(3'b001, 2'd1, 3);
        add_rep(3'b010, 2'd2, 3);
        add_rep(3'b100, 2'd3, 3);
        add(3'b000, 2'd0, 1'b1, 1'b0, 3'd0);
    endtask

    task automatic step(input logic [2:0] v);
        @(negedge clk);
        {q3, q2, q1} = v;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] outs();
        return {phase, busy, done, err, err_code, seq_cnt, err_cnt};
    endfunction

    function automatic logic [23:0] pack(input vec_t r);
        return {r.phase, r.busy, r.done, r.err, r.code, r.scnt, r.ecnt};
    endfunction

    logic [2:0] legal_v  [10] = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b010,
                                  3'b010, 3'b100, 3'b100, 3'b100, 3'b000};
    logic [1:0] legal_ph [10] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2,
                                  2'd2, 2'd3, 2'd3, 2'd3, 2'd0};

    initial begin
        rst_n = 1'b0;
        {q3, q2, q1} = 3'b000;

        // Two back-to-back legal sequences sharing the terminating idle cycle.
        add_legal();
        add_legal();
        // LONG on the 4th 001; further 001 in ERR is not reported.
        add_rep(3'b001, 2'd1, 3);
        add(3'b001, 2'd0, 1'b0, 1'b1, 3'd3);
        add(3'b001, 2'd0, 1'b0, 1'b0, 3'd0);
        add(3'b000, 2'd0, 1'b0, 1'b0, 3'd0);
        // SHORT, then a legal sequence completes.
        add_rep(3'b001, 2'd1, 2);
        add(3'b010, 2'd0, 1'b0, 1'b1, 3'd4);
        add(3'b000, 2'd0, 1'b0, 1'b0, 3'd0);
        add_legal();
        // ONEHOT in IDLE.
        add(3'b011, 2'd0, 1'b0, 1'b1, 3'd1);
        add(3'b000, 2'd0, 1'b0, 1'b0, 3'd0);
        // ORDER: P1 straight to q3.
        add_rep(3'b001, 2'd1, 3);
        add(3'b100, 2'd0, 1'b0, 1'b1, 3'd2);
        add(3'b000, 2'd0, 1'b0, 1'b0, 3'd0);
        // ORDER: q2 from IDLE.
        add(3'b010, 2'd0, 1'b0, 1'b1, 3'd2);
        add(3'b000, 2'd0, 1'b0, 1'b0, 3'd0);
        // ORDER: idle lines during P1.
        add(3'b001, 2'd1, 1'b0, 1'b0, 3'd0);
        add(3'b000, 2'd0, 1'b0, 1'b1, 3'd2);
        add(3'b000, 2'd0, 1'b0, 1'b0, 3'd0);
        // ONEHOT during P2 overrides the phase rules.
        add_rep(3'b001, 2'd1, 3);
        add(3'b010, 2'd2, 1'b0, 1'b0, 3'd0);
        add(3'b110, 2'd0, 1'b0, 1'b1, 3'd1);
        add(3'b000, 2'd0, 1'b0, 1'b0, 3'd0);
        // ORDER: q1 directly after a full P3.
        add_rep(3'b001, 2'd1, 3);
        add_rep(3'b010, 2'd2, 3);
        add_rep(3'b100, 2'd3, 3);
        add(3'b001, 2'd0, 1'b0, 1'b1, 3'd2);
        add(3'b000, 2'd0, 1'b0, 1'b0, 3'd0);
        // SHORT: P3 dropped after two cycles.
        add_rep(3'b001, 2'd1, 3);
        add_rep(3'b010, 2'd2, 3);
        add_rep(3'b100, 2'd3, 2);
        add(3'b000, 2'd0, 1'b0, 1'b1, 3'd4);
        add(3'b000, 2'd0, 1'b0, 1'b0, 3'd0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {8'd0, outs()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].v);
            check($sformatf("row%0d", i), {8'd0, outs()}, {8'd0, pack(tbl[i])});
        end

        // Asynchronous reset mid-P2 clears everything without a clock edge.
        step(3'b001); step(3'b001); step(3'b001);
        step(3'b010); step(3'b010);
        check("pre_reset_phase", {30'd0, phase}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {8'd0, outs()}, 32'd0);
        step(3'b010);
        check("reset_hold1", {8'd0, outs()}, 32'd0);
        step(3'b100);
        check("reset_hold2", {8'd0, outs()}, 32'd0);
        @(negedge clk);
        {q3, q2, q1} = 3'b000;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(legal_v[i]);
            check($sformatf("post_reset_ph%0d", i), {30'd0, phase}, {30'd0, legal_ph[i]});
        end
        check("post_reset_done", {8'd0, outs()},
              {8'd0, 2'd0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd1, 8'd0});
        step(3'b000);
        check("done_one_cycle", {31'd0, done}, 32'd0);

        // Error counter saturates at 255 and does not wrap.
        for (int i = 0; i < 256; i++) begin
            step(3'b011);
            step(3'b000);
        end
        check("err_cnt_sat", {24'd0, err_cnt}, 32'd255);
        step(3'b011);
        check("err_at_sat", {8'd0, outs()},
              {8'd0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd1, 8'd1, 8'd255});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pcm_seq_checker
`default_nettype wire
